// File: rtl/dfi_wrdata_sched.sv
// dfi_wrdata_sched
// Controller-side DFI write-data scheduler. It buffers write beats from the
// controller datapath. For each write command issued on DFI it raises
// dfi_wrdata_en TPHY_WRLAT clks later. It drives each beat on
// dfi_wrdata/dfi_wrdata_mask TPHY_WRDATA clks after that. A command is
// accepted only when a full, unreserved burst is already buffered, so the
// data path cannot underrun.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_cmd_valid/wr_cmd_ready   write command issued on DFI when both high
//   wd_valid/wd_ready           write beat handshake into the data FIFO
//   wd_data, wd_mask, wd_last   beat payload, byte mask (1=masked), last flag
//   dfi_wrdata_en               registered DFI write-data enable (all slices)
//   dfi_wrdata, dfi_wrdata_mask registered DFI write data / mask, 0 when idle
//   proto_err                   sticky: wd_last not on the burst boundary
//   busy                        a burst is reserved, scheduled or in flight
module dfi_wrdata_sched #(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned MASK_W      = 8,
   parameter int unsigned EN_W        = 4,
   parameter int unsigned BURST_BEATS = 4,
   parameter int unsigned TPHY_WRLAT  = 3,
   parameter int unsigned TPHY_WRDATA = 1,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_cmd_valid,
   output logic              wr_cmd_ready,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   input  logic [MASK_W-1:0] wd_mask,
   input  logic              wd_last,
   output logic [EN_W-1:0]   dfi_wrdata_en,
   output logic [DATA_W-1:0] dfi_wrdata,
   output logic [MASK_W-1:0] dfi_wrdata_mask,
   output logic              proto_err,
   output logic              busy
);

   // Bit k of a line in cycle c marks a command accepted in cycle c-1-k.
   // The registered outputs are loaded from the next-state value of the line,
   // so the active window is always the top BURST_BEATS bits. The line stops
   // one bit short of the full latency, so busy drops right after the final
   // data cycle.
   localparam int unsigned EN_D  = TPHY_WRLAT + BURST_BEATS - 1;
   localparam int unsigned DAT_D = TPHY_WRLAT + TPHY_WRDATA + BURST_BEATS - 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IDX_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

   logic [EN_D-1:0]          en_line, en_next;
   logic [DAT_D-1:0]         dat_line, dat_next;
   logic [CNT_W-1:0]         count, reserved, avail;
   logic [IDX_W-1:0]         spacing, beat_idx;
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [MASK_W+DATA_W-1:0] mem [FIFO_DEPTH];
   logic [MASK_W+DATA_W-1:0] head;
   logic                     accept, push, pop, en_on, last_slot;

   assign avail        = count - reserved;
   assign wr_cmd_ready = !reset && (avail >= CNT_W'(BURST_BEATS)) && (spacing == '0);
   assign wd_ready     = !reset && (count < CNT_W'(FIFO_DEPTH));
   assign accept       = wr_cmd_valid && wr_cmd_ready;
   assign push         = wd_valid && wd_ready;
   assign head         = mem[rd_ptr];
   assign last_slot    = (beat_idx == IDX_W'(BURST_BEATS - 1));
   assign busy         = (reserved != '0) || (|en_line) || (|dat_line);

   always_comb begin
      en_next     = '0;
      dat_next    = '0;
      en_next[0]  = accept;
      dat_next[0] = accept;
      for (int unsigned i = 1; i < EN_D; i++) en_next[i] = en_line[i-1];
      for (int unsigned i = 1; i < DAT_D; i++) dat_next[i] = dat_line[i-1];
      en_on = |en_next[EN_D-1 -: BURST_BEATS];
      pop   = |dat_next[DAT_D-1 -: BURST_BEATS];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wd_mask, wd_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_line         <= '0;
         dat_line        <= '0;
         dfi_wrdata_en   <= '0;
         dfi_wrdata      <= '0;
         dfi_wrdata_mask <= '0;
         count           <= '0;
         reserved        <= '0;
         spacing         <= '0;
         beat_idx        <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         proto_err       <= 1'b0;
      end else begin
         if (pop) assert (count != '0);
         en_line       <= en_next;
         dat_line      <= dat_next;
         dfi_wrdata_en <= {EN_W{en_on}};
         if (pop) begin
            dfi_wrdata      <= head[DATA_W-1:0];
            dfi_wrdata_mask <= head[DATA_W +: MASK_W];
            rd_ptr          <= rd_ptr + 1'b1;
         end else begin
            dfi_wrdata      <= '0;
            dfi_wrdata_mask <= '0;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         reserved <= reserved + (accept ? CNT_W'(BURST_BEATS) : '0)
                              - (pop ? CNT_W'(1) : '0);
         if (accept)              spacing <= IDX_W'(BURST_BEATS - 1);
         else if (spacing != '0)  spacing <= spacing - 1'b1;
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            beat_idx <= last_slot ? '0 : beat_idx + 1'b1;
            if (wd_last != last_slot) proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dfi_wrdata_sched.sv
module tb_dfi_wrdata_sched;
   localparam int BB = 4, L = 3, W = 1, DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_cmd_valid = 1'b0, wd_valid = 1'b0, wd_last = 1'b0;
   logic [63:0] wd_data = '0;
   logic [7:0]  wd_mask = '0;
   logic        wr_cmd_ready, wd_ready, proto_err, busy;
   logic [3:0]  dfi_wrdata_en;
   logic [63:0] dfi_wrdata;
   logic [7:0]  dfi_wrdata_mask;

   always #5 clk = ~clk;

   dfi_wrdata_sched #(
      .DATA_W(64), .MASK_W(8), .EN_W(4), .BURST_BEATS(BB),
      .TPHY_WRLAT(L), .TPHY_WRDATA(W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
      .wd_valid(wd_valid), .wd_ready(wd_ready),
      .wd_data(wd_data), .wd_mask(wd_mask), .wd_last(wd_last),
      .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
      .dfi_wrdata_mask(dfi_wrdata_mask),
      .proto_err(proto_err), .busy(busy)
   );

   int unsigned n_vec = 0, n_err = 0;
   int          cyc = 0;
   int          acc_t[$];        // cycles in which commands were accepted since reset
   logic [71:0] beats[$];        // {mask,data} of every beat pushed since reset
   bit          exp_proto = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // then fold the handshakes of this cycle into the model.
   task automatic step(input bit rst, input bit cv, input bit dv,
                       input logic [63:0] d, input logic [7:0] m, input bit lst);
      int pops, cnt, rsv, k;
      bit en, bsy, cr, dr;
      logic [63:0] ed;
      logic [7:0]  em;
      @(posedge clk); #1;
      reset = rst; wr_cmd_valid = cv; wd_valid = dv;
      wd_data = d; wd_mask = m; wd_last = lst;
      cyc++;
      @(negedge clk);
      pops = 0; en = 0; bsy = 0; ed = '0; em = '0;
      foreach (acc_t[n]) begin
         k = cyc - (acc_t[n] + L + W);
         if (k >= BB) pops += BB;
         else if (k >= 0) begin
            pops += k + 1;
            ed = beats[n*BB + k][63:0];
            em = beats[n*BB + k][71:64];
         end
         if (cyc >= acc_t[n] + L && cyc <= acc_t[n] + L + BB - 1) en = 1;
         if (cyc > acc_t[n] && cyc <= acc_t[n] + L + W + BB - 1) bsy = 1;
      end
      cnt = beats.size() - pops;
      rsv = acc_t.size() * BB - pops;
      dr  = !rst && cnt < DEPTH;
      cr  = !rst && (cnt - rsv) >= BB && (acc_t.size() == 0 || cyc - acc_t[$] >= BB);
      check("wr_cmd_ready", 64'(wr_cmd_ready), 64'(cr));
      check("wd_ready", 64'(wd_ready), 64'(dr));
      check("dfi_wrdata_en", 64'(dfi_wrdata_en), en ? 64'hF : 64'h0);
      check("dfi_wrdata", dfi_wrdata, ed);
      check("dfi_wrdata_mask", 64'(dfi_wrdata_mask), 64'(em));
      check("busy", 64'(busy), 64'(bsy));
      check("proto_err", 64'(proto_err), 64'(exp_proto));
      if (rst) begin
         acc_t.delete();
         beats.delete();
         exp_proto = 1'b0;
      end else begin
         if (cv && cr) acc_t.push_back(cyc);
         if (dv && dr) begin
            if (lst != ((beats.size() % BB) == BB - 1)) exp_proto = 1'b1;
            beats.push_back({m, d});
         end
      end
   endtask

   function automatic bit good_last();
      return (beats.size() % BB) == BB - 1;
   endfunction

   task automatic push_beat(input bit cv);
      step(0, cv, 1, {$urandom, $urandom}, 8'($urandom), good_last());
   endtask

   task automatic idle(input int n, input bit cv);
      for (int i = 0; i < n; i++) step(0, cv, 0, '0, '0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, '0, '0, 0);
      step(1, 0, 0, '0, '0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      do_reset();

      // single burst
      for (int i = 0; i < BB; i++) push_beat(0);
      idle(2, 0);
      idle(1, 1);
      idle(12, 0);

      // back-to-back bursts from a full buffer, command held valid
      for (int i = 0; i < 2*BB; i++) push_beat(0);
      idle(BB + 1, 1);
      idle(14, 0);

      // command before data
      for (int i = 0; i < BB - 1; i++) push_beat(0);
      idle(2, 1);
      push_beat(1);
      idle(2, 1);
      idle(12, 0);

      // FIFO full, then drain with data still offered
      for (int i = 0; i < DEPTH + 2; i++) push_beat(0);
      idle(1, 1);
      for (int i = 0; i < 8; i++) push_beat(0);
      idle(1, 1);
      idle(14, 0);

      // protocol error: wd_last on beat index 2
      do_reset();
      push_beat(0);
      push_beat(0);
      step(0, 0, 1, 64'h1234, 8'h0F, 1'b1);
      push_beat(0);
      idle(4, 0);

      // reset mid-burst, then a clean burst
      do_reset();
      for (int i = 0; i < BB; i++) push_beat(0);
      idle(1, 1);
      idle(4, 0);
      step(1, 0, 0, '0, '0, 0);
      idle(3, 0);
      for (int i = 0; i < BB; i++) push_beat(0);
      idle(1, 1);
      idle(12, 0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         bit r, cv, dv, lst;
         r   = ($urandom_range(0, 299) == 0);
         cv  = ($urandom_range(0, 1) == 1);
         dv  = ($urandom_range(0, 9) < 6);
         lst = good_last();
         if ($urandom_range(0, 99) == 0) lst = !lst;
         step(r, cv, dv, {$urandom, $urandom}, 8'($urandom), lst);
      end
      idle(20, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
